// File: rtl/ahb_dec5_pkg.sv
// Shared AHB-Lite codes and default-slave types for the 5-region decoder.
package ahb_pkg;

  localparam int NSLV = 5;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HR_OKAY  = 1'b0,
    HR_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  typedef struct packed {
    logic   hreadyout;
    hresp_e hresp;
  } ds_rsp_t;

  // NONSEQ/SEQ carry a real transfer; IDLE/BUSY must get a zero-wait OKAY
  function automatic logic is_active(input logic [1:0] t);
    return (t == HT_NONSEQ) || (t == HT_SEQ);
  endfunction

endpackage

// File: rtl/ahb_dec5_if.sv
// Address-bus inputs and select/default-slave outputs of the 5-region decoder.
interface ahb_dec5_if #(parameter int AW = 32);
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hready;
  logic          hsel0, hsel1, hsel2, hsel3, hsel4;
  logic          dsel0, dsel1, dsel2, dsel3, dsel4;
  logic          dsel_dflt;
  logic          dflt_hreadyout;
  logic          dflt_hresp;

  modport master (
    output haddr, htrans, hready,
    input  hsel0, hsel1, hsel2, hsel3, hsel4,
    input  dsel0, dsel1, dsel2, dsel3, dsel4, dsel_dflt,
    input  dflt_hreadyout, dflt_hresp
  );

  modport slave (
    input  haddr, htrans, hready,
    output hsel0, hsel1, hsel2, hsel3, hsel4,
    output dsel0, dsel1, dsel2, dsel3, dsel4, dsel_dflt,
    output dflt_hreadyout, dflt_hresp
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for unmapped active transfers.
// Optional error counter enabled by AHB_DEC_ERR_CNT_EN.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic        unmapped,
  output logic        hreadyout,
  output logic        hresp
`ifdef AHB_DEC_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  ds_state_e st, st_nxt;
  ds_rsp_t   rsp;
  logic      err_start;

  assign err_start = hready & is_active(htrans) & unmapped;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) st <= DS_OKAY;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    rsp    = '{hreadyout: 1'b1, hresp: HR_OKAY};
    case (st)
      DS_OKAY: if (err_start) st_nxt = DS_ERR1;
      DS_ERR1: begin
        rsp    = '{hreadyout: 1'b0, hresp: HR_ERROR};
        st_nxt = DS_ERR2;
      end
      // a new unmapped transfer accepted here chains straight into ERR1
      DS_ERR2: begin
        rsp    = '{hreadyout: 1'b1, hresp: HR_ERROR};
        st_nxt = err_start ? DS_ERR1 : DS_OKAY;
      end
      default: st_nxt = DS_OKAY;
    endcase
  end

  assign hreadyout = rsp.hreadyout;
  assign hresp     = rsp.hresp;

`ifdef AHB_DEC_ERR_CNT_EN
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst)
      err_cnt <= '0;
    else if (err_start && (st != DS_ERR1) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: rtl/ahb_dec5.sv
// 5-region AHB-Lite address decoder with data-phase select register and
// built-in default slave. Optional AHB_DEC_ERR_CNT_EN adds err_cnt.
module ahb_dec5
  import ahb_pkg::*;
#(
  parameter int          AW      = 32,
  parameter logic [AW-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [AW-1:0] S0_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S1_BASE = 32'h1000_0000,
  parameter logic [AW-1:0] S1_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S2_BASE = 32'h2000_0000,
  parameter logic [AW-1:0] S2_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S3_BASE = 32'h4000_0000,
  parameter logic [AW-1:0] S3_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S4_BASE = 32'h8000_0000,
  parameter logic [AW-1:0] S4_MASK = 32'hF000_0000
)(
  input  logic        hclk,
  input  logic        hrst,
  ahb_dec5_if.slave   bus
`ifdef AHB_DEC_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  // {dsel_dflt, dsel4..dsel0}; default slave owns the data phase out of reset
  localparam logic [NSLV:0] DSEL_RST = {1'b1, {NSLV{1'b0}}};

  logic [NSLV-1:0][AW-1:0] base, mask;
  logic [NSLV-1:0]         m, hsel;
  logic [NSLV:0]           dsel_q;
  logic                    unmapped;

  assign base = {S4_BASE, S3_BASE, S2_BASE, S1_BASE, S0_BASE};
  assign mask = {S4_MASK, S3_MASK, S2_MASK, S1_MASK, S0_MASK};

  genvar i;
  generate
    for (i = 0; i < NSLV; i++) begin : g_rgn
      assign m[i] = ((bus.haddr & mask[i]) == base[i]);
      // lowest index wins on overlapping regions
      if (i == 0) begin : g_first
        assign hsel[i] = m[i];
      end else begin : g_rest
        assign hsel[i] = m[i] & ~(|m[i-1:0]);
      end
    end
  endgenerate

  assign unmapped = ~(|m);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst)            dsel_q <= DSEL_RST;
    else if (bus.hready) dsel_q <= {unmapped, hsel};
  end

  assign bus.hsel0     = hsel[0];
  assign bus.hsel1     = hsel[1];
  assign bus.hsel2     = hsel[2];
  assign bus.hsel3     = hsel[3];
  assign bus.hsel4     = hsel[4];
  assign bus.dsel0     = dsel_q[0];
  assign bus.dsel1     = dsel_q[1];
  assign bus.dsel2     = dsel_q[2];
  assign bus.dsel3     = dsel_q[3];
  assign bus.dsel4     = dsel_q[4];
  assign bus.dsel_dflt = dsel_q[NSLV];

  ahb_default_slave u_dflt (
    .hclk      (hclk),
    .hrst      (hrst),
    .hready    (bus.hready),
    .htrans    (bus.htrans),
    .unmapped  (unmapped),
    .hreadyout (bus.dflt_hreadyout),
    .hresp     (bus.dflt_hresp)
`ifdef AHB_DEC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

endmodule

// File: tb/tb_ahb_dec5.sv
// Scoreboard bench for ahb_dec5: driver queues hand-computed expectations,
// negedge monitor pops and compares. Second instance covers region overlap.
module tb_ahb_dec5;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hrst;
  always #5 hclk = ~hclk;

  ahb_dec5_if #(.AW(32)) bus  ();
  ahb_dec5_if #(.AW(32)) obus ();

`ifdef AHB_DEC_ERR_CNT_EN
  logic [15:0] err_cnt, oerr_cnt;
`endif

  ahb_dec5 u_dut (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (bus.slave)
`ifdef AHB_DEC_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  ahb_dec5 #(.S1_BASE(32'h0000_0000), .S1_MASK(32'h0000_0000)) u_ovl (
    .hclk (hclk),
    .hrst (hrst),
    .bus  (obus.slave)
`ifdef AHB_DEC_ERR_CNT_EN
    ,
    .err_cnt (oerr_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  hsel;
    logic [5:0]  dsel;
    logic        ro;
    logic        rsp;
    logic [4:0]  ohsel;
    logic [15:0] ecnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge hclk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".hsel"}, 32'({bus.hsel4, bus.hsel3, bus.hsel2, bus.hsel1, bus.hsel0}), 32'(e.hsel));
      chk({e.nm, ".dsel"}, 32'({bus.dsel_dflt, bus.dsel4, bus.dsel3, bus.dsel2, bus.dsel1, bus.dsel0}), 32'(e.dsel));
      chk({e.nm, ".rsp"}, 32'({bus.dflt_hreadyout, bus.dflt_hresp}), 32'({e.ro, e.rsp}));
      chk({e.nm, ".ovl_hsel"}, 32'({obus.hsel4, obus.hsel3, obus.hsel2, obus.hsel1, obus.hsel0}), 32'(e.ohsel));
`ifdef AHB_DEC_ERR_CNT_EN
      chk({e.nm, ".err_cnt"}, 32'(err_cnt), 32'(e.ecnt));
`endif
    end
  end

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
    bus.haddr  = a; bus.htrans  = t; bus.hready  = r;
    obus.haddr = a; obus.htrans = t; obus.hready = r;
  endtask

  // one bus cycle: inputs applied just after the edge, outputs checked at negedge
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic r,
                      input logic [4:0] eh, input logic [5:0] ed, input logic ero,
                      input logic ersp, input logic [4:0] eo, input logic [15:0] ec,
                      input string nm);
    @(posedge hclk); #1;
    drive(a, t, r);
    q.push_back('{eh, ed, ero, ersp, eo, ec, nm});
  endtask

  // reset asserted mid-cycle; checked before any further clock edge
  task automatic rst_pulse(input logic [4:0] eh, input logic [4:0] eo, input string nm);
    @(posedge hclk); #3;
    hrst = 1'b1;
    bus.hready = 1'b0; obus.hready = 1'b0;
    q.push_back('{eh, 6'b100000, 1'b1, 1'b0, eo, 16'd0, nm});
    @(posedge hclk); #1;
    hrst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst = 1'b1;
    drive(32'h0, HT_IDLE, 1'b0);
    #2;
    q.push_back('{5'b00001, 6'b100000, 1'b1, 1'b0, 5'b00001, 16'd0, "reset"});
    @(posedge hclk); #1;
    hrst = 1'b0;

    //   haddr         htrans     rdy   hsel      dsel       ro    rsp   ovl_hsel  ecnt
    step(32'h0000_0010, HT_NONSEQ, 1'b1, 5'b00001, 6'b100000, 1'b1, 1'b0, 5'b00001, 16'd0, "r0");
    step(32'h1000_0000, HT_NONSEQ, 1'b1, 5'b00010, 6'b000001, 1'b1, 1'b0, 5'b00010, 16'd0, "r1");
    step(32'h2FFF_FFFC, HT_NONSEQ, 1'b1, 5'b00100, 6'b000010, 1'b1, 1'b0, 5'b00010, 16'd0, "r2");
    step(32'h4000_0000, HT_NONSEQ, 1'b1, 5'b01000, 6'b000100, 1'b1, 1'b0, 5'b00010, 16'd0, "r3");
    step(32'h8000_1234, HT_NONSEQ, 1'b1, 5'b10000, 6'b001000, 1'b1, 1'b0, 5'b00010, 16'd0, "r4");
    step(32'h3000_0000, HT_IDLE,   1'b1, 5'b00000, 6'b010000, 1'b1, 1'b0, 5'b00010, 16'd0, "unm_idle");
    step(32'h3000_0000, HT_IDLE,   1'b1, 5'b00000, 6'b100000, 1'b1, 1'b0, 5'b00010, 16'd0, "unm_idle_ok");
    step(32'h3000_0000, HT_NONSEQ, 1'b1, 5'b00000, 6'b100000, 1'b1, 1'b0, 5'b00010, 16'd0, "unm_ns");
    step(32'h0000_0000, HT_IDLE,   1'b0, 5'b00001, 6'b100000, 1'b0, 1'b1, 5'b00001, 16'd1, "err1");
    step(32'h0000_0000, HT_IDLE,   1'b1, 5'b00001, 6'b100000, 1'b1, 1'b1, 5'b00001, 16'd1, "err2");
    step(32'h0000_0000, HT_IDLE,   1'b1, 5'b00001, 6'b000001, 1'b1, 1'b0, 5'b00001, 16'd1, "err_done");
    // back-to-back unmapped: second NONSEQ accepted in the ERR2 cycle
    step(32'h3000_0000, HT_NONSEQ, 1'b1, 5'b00000, 6'b000001, 1'b1, 1'b0, 5'b00010, 16'd1, "b2b_a");
    step(32'h3000_0000, HT_NONSEQ, 1'b0, 5'b00000, 6'b100000, 1'b0, 1'b1, 5'b00010, 16'd2, "b2b_err1a");
    step(32'h3000_0000, HT_NONSEQ, 1'b1, 5'b00000, 6'b100000, 1'b1, 1'b1, 5'b00010, 16'd2, "b2b_err2a");
    step(32'h1000_0000, HT_NONSEQ, 1'b0, 5'b00010, 6'b100000, 1'b0, 1'b1, 5'b00010, 16'd3, "b2b_err1b");
    step(32'h1000_0000, HT_NONSEQ, 1'b1, 5'b00010, 6'b100000, 1'b1, 1'b1, 5'b00010, 16'd3, "b2b_err2b");
    // wait states from slave 1 while the address moves on
    step(32'h2000_0000, HT_NONSEQ, 1'b0, 5'b00100, 6'b000010, 1'b1, 1'b0, 5'b00010, 16'd3, "wait_a");
    step(32'h4000_0000, HT_SEQ,    1'b0, 5'b01000, 6'b000010, 1'b1, 1'b0, 5'b00010, 16'd3, "wait_b");
    step(32'h4000_0000, HT_SEQ,    1'b1, 5'b01000, 6'b000010, 1'b1, 1'b0, 5'b00010, 16'd3, "wait_rel");
    step(32'h0000_0000, HT_IDLE,   1'b1, 5'b00001, 6'b001000, 1'b1, 1'b0, 5'b00001, 16'd3, "post_wait");
    rst_pulse(5'b00001, 5'b00001, "rst_dsel");
    step(32'h3000_0000, HT_NONSEQ, 1'b1, 5'b00000, 6'b100000, 1'b1, 1'b0, 5'b00010, 16'd0, "pre_rst_err");
    rst_pulse(5'b00000, 5'b00010, "rst_mid_err");
    step(32'h0000_0000, HT_IDLE,   1'b1, 5'b00001, 6'b100000, 1'b1, 1'b0, 5'b00001, 16'd0, "post_rst");

    @(posedge hclk);
    @(negedge hclk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_dec5.md
Name: ahb_dec5

Overview:
- 5-region AHB-Lite address decoder with a built-in default slave.
- Generates the one-hot address-phase HSEL for 5 slaves and the registered data-phase selects that drive the 5:1 response/read-data mux sel inputs.
- Unmapped transfers are absorbed by an internal default slave that returns a two-cycle ERROR response.
- Sits between the master address bus and the slave ports; dsel* and the default-slave outputs feed the slave-to-master return mux.

Parameters:
AW, 32, address width
S0_BASE / S0_MASK, 32'h0000_0000 / 32'hF000_0000, region 0 match: (haddr & MASK) == BASE
S1_BASE / S1_MASK, 32'h1000_0000 / 32'hF000_0000, region 1
S2_BASE / S2_MASK, 32'h2000_0000 / 32'hF000_0000, region 2
S3_BASE / S3_MASK, 32'h4000_0000 / 32'hF000_0000, region 3
S4_BASE / S4_MASK, 32'h8000_0000 / 32'hF000_0000, region 4

Ports:
hclk  in  1  bus clock
hrst  in  1  asynchronous active-high reset
haddr  in  AW  address-phase address
htrans  in  2  transfer type
hready  in  1  bus-level HREADY (output of return mux)
hsel0..hsel4  out  1 each  address-phase slave selects, one-hot or all-zero
dsel0..dsel4  out  1 each  data-phase selects to return mux
dsel_dflt  out  1  data-phase select of default slave
dflt_hreadyout  out  1  default slave HREADYOUT
dflt_hresp  out  1  default slave HRESP (1 = ERROR)

Behaviour:
- Clocking: one clock, hclk. Reset is asynchronous and active-high (hrst); polarity and synchronicity are fixed.
- Region match: mN = ((haddr & SN_MASK) == SN_BASE).
- Priority on overlap: lowest index wins. hselN = mN & ~m0..m(N-1).
- hsel*: purely combinational from haddr. Not qualified by htrans or hready; slaves qualify them.
- Unmapped: no mN set; hsel* all zero; default slave selected.
- Data-phase register: when hready=1, dsel0..4 <= hsel0..4 and dsel_dflt <= ~|hsel. When hready=0, hold.
- Outputs dsel0..dsel4 and dsel_dflt are one-hot at all times.
- Reset values: dsel0..4=0, dsel_dflt=1, dflt_hreadyout=1, dflt_hresp=0. The bus is therefore ready out of reset.
- Default slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
  - DS_OKAY: hreadyout=1, hresp=0. If hready=1 & htrans[1]=1 (NONSEQ/SEQ) & unmapped -> DS_ERR1; else stay.
  - DS_ERR1: hreadyout=0, hresp=1. Unconditionally -> DS_ERR2.
  - DS_ERR2: hreadyout=1, hresp=1. If hready=1 & htrans[1] & unmapped -> DS_ERR1; else -> DS_OKAY.
- IDLE/BUSY to unmapped address: zero-wait OKAY, state unchanged.
- Back-to-back unmapped transfers: ERR1, ERR2, ERR1, ERR2... with no OKAY cycle between.
- Reset mid-ERROR: async return to DS_OKAY with reset outputs.
- Latency: hsel has 0-cycle latency; dsel follows with 1 cycle after hready=1.

Optional Feature:
- Macro AHB_DEC_ERR_CNT_EN.
- Defined:
  - Extra output err_cnt[15:0]. Increments on each DS_OKAY/DS_ERR2 -> DS_ERR1 transition.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP codes: OKAY=0, ERROR=1.
  - Default-slave state encoding.
- Sub-module ahb_default_slave holds the FSM and the optional counter; the decoder and data-phase register stay in ahb_dec5.

Test Plan:
- Reset: assert hrst mid-stream -> dsel*=0, dsel_dflt=1, dflt_hreadyout=1, dflt_hresp=0 immediately, without waiting for hclk.
- Each region: NONSEQ to haddr=0x0000_0010, 0x1000_0000, 0x2FFF_FFFC, 0x4000_0000, 0x8000_1234 with hready=1 -> matching hselN same cycle, matching dselN next cycle.
- Overlap: set S1_BASE=0, S1_MASK=0 (matches all); haddr=0x0000_0000 -> hsel0=1, hsel1=0. haddr=0x3000_0000 -> hsel1=1.
- Unmapped NONSEQ to 0x3000_0000 -> data phase: hreadyout=0/hresp=1, then hreadyout=1/hresp=1, then OKAY. IDLE to same address -> OKAY, no wait.
- Back-to-back unmapped NONSEQ issued in the ERR2 cycle -> ERR1 follows ERR2 directly. With AHB_DEC_ERR_CNT_EN, err_cnt=2. Preload near 16'hFFFF -> holds at 16'hFFFF.
- hready=0 wait states from a selected slave while haddr changes -> dsel* held stable until hready=1.
